// File: rtl/counter_apb_master.sv
// counter_apb_master
//   Command-driven APB master for the up/down counter's register block.
//   Each accepted command becomes one APB SETUP/ACCESS transfer and
//   produces exactly one single-cycle response.
//
// Ports
//   pclk, preset          clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                0=EN, 1=RST_N, 2=DIR (writes), 3=COUNT (read)
//   cmd_wdata             write data (ignored for op 3)
//   rsp_valid             one-cycle response strobe
//   rsp_rdata, rsp_err    read data (0 for writes/errors), error flag
//   paddr, pwdata, pwrite, psel, penable   APB request
//   prdata, pready, pslverr                APB completion
module counter_apb_master #(
  parameter logic [31:0] BASE_ADDR = 32'd1,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        pwrite,
  output logic        psel,
  output logic        penable,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam int unsigned TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  // Count value seen during the last permitted wait cycle.
  localparam logic [TW-1:0] TLAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tcnt;
  logic          timeout_hit;

  // psel/penable decode straight from the state register so that an
  // asynchronous reset drops them in the same cycle.
  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    psel        = 1'b0;
    penable     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = SETUP;
      end
      SETUP: begin
        psel      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        // pready takes priority over an expiring timeout
        if (pready) begin
          state_nxt = RESP;
        end else if ((TIMEOUT != 0) && (tcnt == TLAST)) begin
          timeout_hit = 1'b1;
          state_nxt   = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      tcnt      <= '0;
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            paddr  <= BASE_ADDR + {28'd0, cmd_op, 2'b00};
            pwdata <= (cmd_op == 2'd3) ? '0 : cmd_wdata;
            pwrite <= (cmd_op != 2'd3);
            tcnt   <= '0;
          end
        end
        ACCESS: begin
          if (pready) begin
            rsp_err   <= pslverr;
            rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (timeout_hit) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_apb_master.sv
module tb_counter_apb_master;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_valid0;
  logic        cmd_ready, cmd_ready0;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_valid0;
  logic [31:0] rsp_rdata, rsp_rdata0;
  logic        rsp_err, rsp_err0;
  logic [31:0] paddr, paddr0, pwdata, pwdata0;
  logic        pwrite, pwrite0, psel, psel0, penable, penable0;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 pclk = ~pclk;

  counter_apb_master #(.BASE_ADDR(32'd1), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  counter_apb_master #(.BASE_ADDR(32'd1), .TIMEOUT(0)) dut0 (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .paddr(paddr0), .pwdata(pwdata0), .pwrite(pwrite0), .psel(psel0), .penable(penable0),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  // One command with a zero-wait slave; checks every phase.
  task automatic do_cmd(input logic [1:0] op, input logic [31:0] wd,
                        input logic [31:0] prd, input logic perr,
                        input logic [31:0] exp_rd, input logic exp_err);
    check("idle_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_wdata = wd;
    pready = 1'b1; prdata = prd; pslverr = perr;
    tick;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_wdata = 32'hBAD0_BAD0;
    check("setup_psel", {30'd0, psel, penable}, 32'd2);
    check("setup_paddr", paddr, 32'd1 + 32'd4 * {30'd0, op});
    check("setup_pwrite", {31'd0, pwrite}, {31'd0, op != 2'd3});
    check("setup_pwdata", pwdata, (op == 2'd3) ? 32'd0 : wd);
    check("setup_ready", {31'd0, cmd_ready}, 32'd0);
    tick;
    check("access_psel", {30'd0, psel, penable}, 32'd3);
    check("access_paddr", paddr, 32'd1 + 32'd4 * {30'd0, op});
    tick;
    check("resp_valid", {30'd0, rsp_valid, psel}, 32'd2);
    check("resp_rdata", rsp_rdata, exp_rd);
    check("resp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    check("resp_ready", {31'd0, cmd_ready}, 32'd0);
    pready = 1'b0; pslverr = 1'b0;
    tick;
    check("back_idle", {30'd0, cmd_ready, rsp_valid}, 32'd2);
  endtask

  initial begin
    logic [7:0] exp_rdy, exp_rv;
    int n;

    preset = 1'b1; cmd_valid = 1'b0; cmd_valid0 = 1'b0; cmd_op = 2'd0;
    cmd_wdata = 32'd0; prdata = 32'd0; pready = 1'b0; pslverr = 1'b0;
    tick; tick;
    // Reset state
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_ctrl", {28'd0, psel, penable, rsp_valid, pwrite}, 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_rsp", {rsp_rdata[30:0], rsp_err}, 32'd0);
    preset = 1'b0;
    tick;

    // Bring-up sequence; writes must return rdata 0 even with prdata driven
    do_cmd(2'd1, 32'd1, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0);
    do_cmd(2'd2, 32'd1, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0);
    do_cmd(2'd0, 32'd1, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0);
    repeat (10) tick;
    do_cmd(2'd3, 32'hFFFF_FFFF, 32'h0000_000A, 1'b0, 32'h0000_000A, 1'b0);

    // Back-to-back: cmd_valid held high, accept every 4 cycles
    exp_rdy = 8'b1000_1000;  // bit i = cmd_ready after tick i+1
    exp_rv  = 8'b0100_0100;
    pready = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd2; cmd_wdata = 32'd5;
    for (int i = 0; i < 8; i++) begin
      tick;
      check("b2b_ready", {31'd0, cmd_ready}, {31'd0, exp_rdy[i]});
      check("b2b_rvalid", {31'd0, rsp_valid}, {31'd0, exp_rv[i]});
    end
    cmd_valid = 1'b0; pready = 1'b0;
    tick;
    check("b2b_idle", {30'd0, cmd_ready, psel}, 32'd2);

    // Three wait states, then prdata 0x1234; garbage ignored while not ready
    cmd_valid = 1'b1; cmd_op = 2'd3;
    tick;
    cmd_valid = 1'b0;
    pready = 1'b0; prdata = 32'hFFFF_0000; pslverr = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) begin
      check("wait_psel", {30'd0, psel, penable}, 32'd3);
      check("wait_paddr", paddr, 32'd13);
      tick;
    end
    check("wait4_psel", {30'd0, psel, penable}, 32'd3);
    check("wait4_paddr", paddr, 32'd13);
    pready = 1'b1; prdata = 32'h0000_1234; pslverr = 1'b0;
    tick;
    check("wait_rvalid", {31'd0, rsp_valid}, 32'd1);
    check("wait_rdata", rsp_rdata, 32'h0000_1234);
    check("wait_err", {31'd0, rsp_err}, 32'd0);
    pready = 1'b0;
    tick;

    // Timeout: pready stuck low, 16 ACCESS cycles then error
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_wdata = 32'd1;
    tick;
    cmd_valid = 1'b0;
    tick;
    n = 0;
    while (penable && n < 40) begin
      n++;
      tick;
    end
    check("to_cycles", n, 32'd16);
    check("to_rvalid", {31'd0, rsp_valid}, 32'd1);
    check("to_err", {31'd0, rsp_err}, 32'd1);
    check("to_rdata", rsp_rdata, 32'd0);
    tick;

    // pready on the cycle the count would expire: normal completion
    cmd_valid = 1'b1; cmd_op = 2'd3;
    tick;
    cmd_valid = 1'b0;
    tick;
    repeat (15) tick;
    check("edge_penable", {31'd0, penable}, 32'd1);
    pready = 1'b1; prdata = 32'h0000_0055; pslverr = 1'b0;
    tick;
    check("edge_rvalid", {31'd0, rsp_valid}, 32'd1);
    check("edge_err", {31'd0, rsp_err}, 32'd0);
    check("edge_rdata", rsp_rdata, 32'h0000_0055);
    pready = 1'b0;
    tick;

    // TIMEOUT=0 instance waits indefinitely
    cmd_valid0 = 1'b1; cmd_op = 2'd1; cmd_wdata = 32'd1;
    tick;
    cmd_valid0 = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (penable0 && !rsp_valid0) n++;
    end
    check("nto_cycles", n, 32'd100);
    pready = 1'b1;
    tick;
    check("nto_rvalid", {30'd0, rsp_valid0, rsp_err0}, 32'd2);
    pready = 1'b0;
    tick;
    check("nto_idle", {31'd0, cmd_ready0}, 32'd1);

    // Slave error on a write, then a clean command
    do_cmd(2'd2, 32'd0, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b1);
    do_cmd(2'd1, 32'd1, 32'd0, 1'b0, 32'd0, 1'b0);

    // Reset during ACCESS abandons the transfer
    cmd_valid = 1'b1; cmd_op = 2'd3;
    tick;
    cmd_valid = 1'b0;
    tick;
    check("mrst_access", {30'd0, psel, penable}, 32'd3);
    preset = 1'b1;
    #1;
    check("mrst_async", {30'd0, psel, penable}, 32'd0);
    n = 0;
    repeat (3) begin
      tick;
      if (rsp_valid) n++;
    end
    preset = 1'b0;
    tick;
    if (rsp_valid) n++;
    check("mrst_norsp", n, 32'd0);
    check("mrst_ready", {31'd0, cmd_ready}, 32'd1);
    do_cmd(2'd3, 32'd0, 32'h0000_0077, 1'b0, 32'h0000_0077, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
